serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
- Serial-in, parallel-out frame receiver built from a D-flip-flop shift chain plus a control FSM.
- Listens on one serial line idle-high and samples one bit per `bit_en` strobe.
- Frame format: start bit (0), DATA_W data bits LSB first, optional parity bit, stop bit (1).
- Acts as the receiving end for the lab's serial frame transmitter and presents each completed word with a one-cycle valid pulse.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 2..16).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  bit-period strobe; `sdi` is sampled only on cycles where `bit_en`=1.
- sdi  input  1  serial data in; idles at 1.
- dout  output  DATA_W  last successfully received word.
- dout_valid  output  1  one-cycle pulse when `dout` is updated.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- parity_err  output  1  one-cycle parity-failure pulse; exists only with PARITY_CHECK_EN.

Behaviour:
- Reset: when `rst`=1 at a clock edge:
  - state goes to IDLE;
  - shift register, bit counter and `dout` go to 0;
  - `dout_valid`, `frame_err`, `parity_err` and `busy` go to 0.
  - `rst` has priority over every other input.
  - Reset mid-frame abandons the frame with no pulses; reception restarts with the next start bit.
- Sampling: on a cycle with `bit_en`=0, the FSM, shift register and counter hold their values.
- State IDLE:
  - `bit_en`=1 and `sdi`=0: start bit accepted, go to DATA, counter cleared.
  - `sdi`=1: stay in IDLE.
- State DATA:
  - On each `bit_en`=1, shift `sdi` into the shift-register MSB and shift right, so the first received bit ends up in bit 0 after DATA_W shifts.
  - Counter increments on each sample.
  - When the DATA_W-th bit is sampled, go to PARITY if the feature is compiled in, otherwise to STOP.
- State PARITY (feature only):
  - On `bit_en`=1, sample the parity bit and go to STOP.
- State STOP, on `bit_en`=1:
  - `sdi`=1: `dout` is loaded from the shift register and `dout_valid`=1 on the following cycle for exactly one cycle.
  - `sdi`=0: `frame_err`=1 for one cycle and `dout` keeps its previous value.
  - In both cases, go to IDLE.
- Latency: `dout`/`dout_valid` change at the clock edge that samples the stop bit (registered outputs); they are visible in the cycle after that `bit_en` cycle.
- Back-to-back frames: the FSM is in IDLE on the cycle after the stop sample, so a start bit at the very next `bit_en` is accepted. No idle bit is required between frames.
- Glitch handling: there is no start-bit revalidation. A 0 sampled in IDLE always starts a frame.
- `busy`: registered; equals (state != IDLE).
- Counter width: `$clog2(DATA_W+1)`; it never wraps within a frame.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - the PARITY state and `parity_err` port exist;
  - the expected bit is even parity (XOR of the data bits XOR the parity bit must equal 0);
  - on mismatch, at the stop sample `parity_err` pulses with the same timing as `dout_valid`/`frame_err`, and `dout` is not updated even if the stop bit is 1;
  - a frame error and a parity error may pulse together.
- Not defined:
  - no PARITY state and no `parity_err` port;
  - the frame is start + DATA_W data bits + stop.

Test Plan:
- Reset check: drive `rst`=1 for 3 cycles with `sdi` toggling -> `dout`=0x00, all pulses 0, `busy`=0. Then `rst`=0 with `sdi`=1 for 10 strobes -> `busy` stays 0.
- Single frame: `bit_en` every 4 clocks, send 0xA5 as bits 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop) -> `busy` high from the start sample until the stop sample; `dout`=0xA5; `dout_valid` high for exactly 1 clock.
- Framing error: send 0x3C with stop bit 0 -> `frame_err` pulses 1 cycle; `dout` retains 0xA5; `dout_valid` stays 0.
- Back-to-back frames: send 0x01 then 0xFF with no idle bit, `bit_en` held at 1 every cycle -> two `dout_valid` pulses 10 cycles apart, `dout`=0x01 then 0xFF.
- Reset mid-frame: assert `rst` after 4 data bits of 0x55 -> no pulses, `busy`=0 next cycle; a subsequent 0x96 frame is received correctly.
- PARITY_CHECK_EN: send 0x07 with parity 1 -> `dout`=0x07, `dout_valid`=1. Send 0x07 with parity 0 -> `parity_err` pulses and `dout` is unchanged.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/data(LSB first)/[parity]/stop receiver, one sample per bit_en strobe.
// Latency: dout/dout_valid/frame_err/parity_err update on the edge that samples the stop bit.
// Backpressure: none; the receiver holds all state on cycles with bit_en=0.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   bit_en, sdi         - bit-period strobe and idle-high serial input
//   dout, dout_valid    - last good word and its one-cycle update pulse
//   frame_err           - one-cycle pulse when the stop bit samples as 0
//   busy                - high while a frame is in progress
//   parity_err          - one-cycle even-parity failure pulse (PARITY_CHECK_EN only)
//
// Build option: define PARITY_CHECK_EN to add an even-parity bit between the
// last data bit and the stop bit, and the parity_err output.
module serial_frame_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              sdi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              frame_err,
`ifdef PARITY_CHECK_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;
`endif

    state_t            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] dout_q;
    logic              valid_q;
    logic              ferr_q;
    logic              busy_q;
`ifdef PARITY_CHECK_EN
    // Running XOR of data bits and the parity bit; 0 means even parity holds.
    logic              par_q;
    logic              perr_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            // Status outputs are single-cycle pulses.
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
            if (bit_en) begin
                case (state_q)
                    S_IDLE: begin
                        // No start-bit revalidation: any sampled 0 opens a frame.
                        if (!sdi) begin
                            state_q <= S_DATA;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
`ifdef PARITY_CHECK_EN
                            par_q   <= 1'b0;
`endif
                        end
                    end
                    S_DATA: begin
                        // Insert at MSB and shift right so the first (LSB) bit
                        // lands in bit 0 after DATA_W samples.
                        shift_q <= {sdi, shift_q[DATA_W-1:1]};
                        cnt_q   <= cnt_q + 1'b1;
`ifdef PARITY_CHECK_EN
                        par_q   <= par_q ^ sdi;
                        if (cnt_q == LAST_BIT) begin
                            state_q <= S_PARITY;
                        end
`else
                        if (cnt_q == LAST_BIT) begin
                            state_q <= S_STOP;
                        end
`endif
                    end
`ifdef PARITY_CHECK_EN
                    S_PARITY: begin
                        par_q   <= par_q ^ sdi;
                        state_q <= S_STOP;
                    end
`endif
                    S_STOP: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (!sdi) begin
                            ferr_q <= 1'b1;
                        end
`ifdef PARITY_CHECK_EN
                        if (par_q) begin
                            perr_q <= 1'b1;
                        end
                        // A word is only published when both stop and parity are good.
                        if (sdi && !par_q) begin
                            dout_q  <= shift_q;
                            valid_q <= 1'b1;
                        end
`else
                        if (sdi) begin
                            dout_q  <= shift_q;
                            valid_q <= 1'b1;
                        end
`endif
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;
`ifdef PARITY_CHECK_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

    localparam int DW = 8;
`ifdef PARITY_CHECK_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          bit_en;
    logic          sdi;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          frame_err;
    logic          busy;
`ifdef PARITY_CHECK_EN
    logic          parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_end_cyc = 0;
    logic [DW-1:0] model_dout;

    serial_frame_rx #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .sdi        (sdi),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_err  (frame_err),
`ifdef PARITY_CHECK_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          stop;
        logic          pbit;
        int            gap;
        logic          exp_valid;
        logic          exp_ferr;
        logic          exp_perr;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one complete frame, checking quiet outputs while it is in flight
    // and the expected result on the stop-sample edge.
    task automatic send_frame(input logic [DW-1:0] data, input logic stop, input logic pbit,
                              input int gap, input logic exp_valid, input logic exp_ferr,
                              input logic exp_perr, input logic [DW-1:0] exp_dout);
        logic bits [NBITS];
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[i+1] = data[i];
`ifdef PARITY_CHECK_EN
        bits[DW+1] = pbit;
`endif
        bits[NBITS-1] = stop;
        for (int k = 0; k < NBITS; k++) begin
            for (int g = 0; g < gap; g++) begin
                bit_en = 1'b0;
                sdi    = 1'($urandom);
                step();
                chk("gap_valid", 32'(dout_valid), 0);
                chk("gap_ferr", 32'(frame_err), 0);
                chk("gap_busy", 32'(busy), (k > 0) ? 1 : 0);
                chk("gap_dout", 32'(dout), 32'(model_dout));
            end
            bit_en = 1'b1;
            sdi    = bits[k];
            step();
            if (k < NBITS - 1) begin
                chk("mid_valid", 32'(dout_valid), 0);
                chk("mid_ferr", 32'(frame_err), 0);
                chk("mid_busy", 32'(busy), 1);
                chk("mid_dout", 32'(dout), 32'(model_dout));
            end else begin
                chk("end_valid", 32'(dout_valid), 32'(exp_valid));
                chk("end_ferr", 32'(frame_err), 32'(exp_ferr));
`ifdef PARITY_CHECK_EN
                chk("end_perr", 32'(parity_err), 32'(exp_perr));
`endif
                chk("end_dout", 32'(dout), 32'(exp_dout));
                chk("end_busy", 32'(busy), 0);
                model_dout   = exp_dout;
                last_end_cyc = cyc;
            end
        end
    endtask

    // Reference outcome of a frame derived from the frame rules alone.
    task automatic run_model_frame(input logic [DW-1:0] data, input logic stop,
                                   input logic pbit, input int gap);
        logic par_ok, v;
`ifdef PARITY_CHECK_EN
        par_ok = ((^data) ^ pbit) == 1'b0;
`else
        par_ok = 1'b1;
`endif
        v = stop && par_ok;
        send_frame(data, stop, pbit, gap, v, !stop, !par_ok, v ? data : model_dout);
    endtask

    initial begin
        int t1;
        rst = 1'b1; bit_en = 1'b1; sdi = 1'b0;
        model_dout = '0;

        // Reset held with sdi toggling.
        for (int i = 0; i < 3; i++) begin
            sdi = ~sdi;
            step();
            chk("rst_dout", 32'(dout), 0);
            chk("rst_valid", 32'(dout_valid), 0);
            chk("rst_ferr", 32'(frame_err), 0);
            chk("rst_busy", 32'(busy), 0);
`ifdef PARITY_CHECK_EN
            chk("rst_perr", 32'(parity_err), 0);
`endif
        end
        rst = 1'b0;
        sdi = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_busy", 32'(busy), 0);
            chk("idle_valid", 32'(dout_valid), 0);
        end

        // Directed table.
        tbl.push_back('{8'hA5, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 8'hA5});
        tbl.push_back('{8'h3C, 1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b0, 8'hA5});
        tbl.push_back('{8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{8'hFF, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'hFF});
        tbl.push_back('{8'h81, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 8'hFF});
        tbl.push_back('{8'h42, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 8'h42});
`ifdef PARITY_CHECK_EN
        tbl.push_back('{8'h07, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 8'h07});
        tbl.push_back('{8'h07, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 8'h07});
        tbl.push_back('{8'h10, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1, 8'h07});
        tbl.push_back('{8'h10, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 8'h10});
`endif
        foreach (tbl[i]) begin
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].pbit, tbl[i].gap,
                       tbl[i].exp_valid, tbl[i].exp_ferr, tbl[i].exp_perr, tbl[i].exp_dout);
        end
        bit_en = 1'b0; sdi = 1'b1;
        step();
        chk("pulse_width", 32'(dout_valid), 0);

        // Back-to-back frames with bit_en held high.
        send_frame(8'h01, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h01);
        t1 = last_end_cyc;
        send_frame(8'hFF, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'hFF);
        chk("b2b_spacing", 32'(last_end_cyc - t1), NBITS);
        bit_en = 1'b0; sdi = 1'b1;
        step();
        chk("b2b_tail_valid", 32'(dout_valid), 0);

        // Reset after 4 data bits of 0x55.
        bit_en = 1'b1; sdi = 1'b0;
        step();
        chk("rmf_busy_start", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            sdi = (i % 2 == 0);
            step();
            chk("rmf_busy", 32'(busy), 1);
        end
        rst = 1'b1; sdi = 1'b1;
        step();
        rst = 1'b0;
        chk("rmf_busy_after", 32'(busy), 0);
        chk("rmf_valid", 32'(dout_valid), 0);
        chk("rmf_ferr", 32'(frame_err), 0);
        chk("rmf_dout", 32'(dout), 0);
        model_dout = '0;
        send_frame(8'h96, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'h96);

        // Randomized frames against the model.
        for (int n = 0; n < 60; n++) begin
            logic [DW-1:0] d;
            logic st, pb;
            d  = DW'($urandom);
            st = ($urandom_range(0, 3) != 0);
            pb = (^d) ^ ($urandom_range(0, 3) == 0);
            run_model_frame(d, st, pb, $urandom_range(0, 3));
        end
        bit_en = 1'b0; sdi = 1'b1;
        step();
        chk("final_valid", 32'(dout_valid), 0);
        chk("final_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
